seq_timer_dev: RTL and testbench

- Responder peripheral on the sequencer's 12-bit instruction bus: programmable 16-bit countdown timer with 8-bit prescaler.
- The sequencer writes opcodes through one oreg_wen bit and polls `ready` through an ireg slot. This gives Seq programs timed waits, such as DDR init delays and LED blink periods, without spin loops in code ROM.
- Clocked on the same clock as the other devices (clock180 domain at top level).

---
 rtl/seq_timer_dev.sv | 123 ++++++++++++
 tb/tb_seq_timer_dev.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_timer_dev.sv
// Sequencer-driven 16-bit countdown timer with 8-bit prescaler.
// Optional sticky expiry flag and CLR opcode (0x7) when SEQ_TIMER_STICKY_EN is defined.
module seq_timer_dev #(
    parameter logic [7:0]  PrescaleReset = 8'h00,
    parameter logic [15:0] CountReset    = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] inst,
    input  logic        inst_en,
    output logic        ready,
    output logic [7:0]  count_o
`ifdef SEQ_TIMER_STICKY_EN
    ,
    output logic        expired
`endif
);

    typedef enum logic {StIdle, StRun} state_e;

    localparam logic [3:0] OpLdl  = 4'h1;
    localparam logic [3:0] OpLdh  = 4'h2;
    localparam logic [3:0] OpLdp  = 4'h3;
    localparam logic [3:0] OpRun  = 4'h4;
    localparam logic [3:0] OpStop = 4'h5;
    localparam logic [3:0] OpSel  = 4'h6;

    state_e      r_state;
    logic [15:0] r_reload;
    logic [15:0] r_live;
    logic [7:0]  r_prescale;
    logic [7:0]  r_pact;
    logic [7:0]  r_pcnt;
    logic        r_sel;

    logic [3:0]  w_op;
    logic [7:0]  w_imm;
    logic        w_run;
    logic        w_stop;
    state_e      w_state_nxt;
    logic [15:0] w_live_nxt;
    logic [7:0]  w_pcnt_nxt;
    logic        w_sel_nxt;
    logic        w_expire;

    assign w_op   = inst[11:8];
    assign w_imm  = inst[7:0];
    assign w_run  = inst_en && (w_op == OpRun);
    assign w_stop = inst_en && (w_op == OpStop);
    assign w_sel_nxt = (inst_en && (w_op == OpSel)) ? w_imm[0] : r_sel;

    // RUN and STOP take priority over the countdown step in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_live_nxt  = r_live;
        w_pcnt_nxt  = r_pcnt;
        w_expire    = 1'b0;
        if (w_run) begin
            w_live_nxt  = r_reload;
            w_pcnt_nxt  = r_prescale;
            w_state_nxt = (r_reload == 16'd0) ? StIdle : StRun;
        end else if (w_stop) begin
            w_state_nxt = StIdle;
        end else if (r_state == StRun) begin
            if (r_pcnt == 8'd0) begin
                w_pcnt_nxt = r_pact;
                w_live_nxt = r_live - 16'd1;
                if (r_live == 16'd1) begin
                    w_state_nxt = StIdle;
                    w_expire    = 1'b1;
                end
            end else begin
                w_pcnt_nxt = r_pcnt - 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_reload   <= CountReset;
            r_prescale <= PrescaleReset;
            r_pact     <= PrescaleReset;
            r_live     <= 16'd0;
            r_pcnt     <= 8'd0;
            r_sel      <= 1'b0;
            ready      <= 1'b1;
            count_o    <= 8'd0;
        end else begin
            if (inst_en && (w_op == OpLdl)) r_reload[7:0]  <= w_imm;
            if (inst_en && (w_op == OpLdh)) r_reload[15:8] <= w_imm;
            if (inst_en && (w_op == OpLdp)) r_prescale     <= w_imm;
            // Prescale in force is latched at RUN so LDP mid-count has no effect.
            if (w_run) r_pact <= r_prescale;
            r_state <= w_state_nxt;
            r_live  <= w_live_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_sel   <= w_sel_nxt;
            ready   <= (w_state_nxt == StIdle);
            count_o <= w_sel_nxt ? w_live_nxt[15:8] : w_live_nxt[7:0];
        end
    end

`ifdef SEQ_TIMER_STICKY_EN
    logic r_expired;
    logic w_clr;

    assign w_clr   = inst_en && (w_op == 4'h7);
    assign expired = r_expired;

    // Expiry wins over a CLR in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_expired <= 1'b0;
        end else if (w_expire) begin
            r_expired <= 1'b1;
        end else if (w_clr) begin
            r_expired <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_seq_timer_dev.sv
// Directed bench for seq_timer_dev; expected outputs queued per step and checked after each edge.
`timescale 1ns/1ps
module tb_seq_timer_dev;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] inst;
    logic        inst_en;
    logic        ready;
    logic [7:0]  count_o;
`ifdef SEQ_TIMER_STICKY_EN
    logic        expired;
`endif

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic       rdy;
        logic [7:0] cnt;
        logic       chk;
        logic       expv;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    seq_timer_dev dut (
        .clock   (clock),
        .reset   (reset),
        .inst    (inst),
        .inst_en (inst_en),
        .ready   (ready),
        .count_o (count_o)
`ifdef SEQ_TIMER_STICKY_EN
        ,
        .expired (expired)
`endif
    );

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, expv);
        end
    endtask

    // Drive one cycle, queue the expected post-edge outputs, then check them.
    task automatic step(input logic en, input logic [3:0] op, input logic [7:0] imm,
                        input logic rdy, input logic [7:0] cnt, input logic chk,
                        input logic expv, input string tag);
        exp_t e;
        inst    = {op, imm};
        inst_en = en;
        e.tag  = tag;
        e.rdy  = rdy;
        e.cnt  = cnt;
        e.chk  = chk;
        e.expv = expv;
        sb.push_back(e);
        @(posedge clock);
        #1;
        inst_en = 1'b0;
        inst    = 12'h000;
        e = sb.pop_front();
        check_bit({e.tag, ".ready"}, ready, e.rdy);
        check_byte({e.tag, ".count"}, count_o, e.cnt);
`ifdef SEQ_TIMER_STICKY_EN
        if (e.chk) check_bit({e.tag, ".expired"}, expired, e.expv);
`endif
    endtask

    task automatic op(input logic [3:0] o, input logic [7:0] imm, input logic rdy,
                      input logic [7:0] cnt, input string tag);
        step(1'b1, o, imm, rdy, cnt, 1'b0, 1'b0, tag);
    endtask

    task automatic idle(input logic rdy, input logic [7:0] cnt, input string tag);
        step(1'b0, 4'h0, 8'h00, rdy, cnt, 1'b0, 1'b0, tag);
    endtask

    initial begin
        reset   = 1'b1;
        inst    = 12'h000;
        inst_en = 1'b0;
        #1 reset = 1'b0;
        #1;
        check_bit("rst.ready", ready, 1'b1);
        check_byte("rst.count", count_o, 8'h00);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;

        // N=5, P=0
        op(4'h1, 8'h05, 1'b1, 8'h00, "t1.ldl");
        op(4'h3, 8'h00, 1'b1, 8'h00, "t1.ldp");
        op(4'h4, 8'h00, 1'b0, 8'h05, "t1.run");
        for (int i = 4; i >= 1; i--) idle(1'b0, 8'(i), "t1.cnt");
        idle(1'b1, 8'h00, "t1.done");
        idle(1'b1, 8'h00, "t1.hold");

        // N=3, P=2: nine busy cycles
        op(4'h1, 8'h03, 1'b1, 8'h00, "t2.ldl");
        op(4'h3, 8'h02, 1'b1, 8'h00, "t2.ldp");
        op(4'h4, 8'h00, 1'b0, 8'h03, "t2.run");
        for (int j = 1; j <= 9; j++) idle(j == 9, 8'(3 - j / 3), "t2.cnt");

        // N=0x0100 with high byte selected
        op(4'h3, 8'h00, 1'b1, 8'h00, "t3.ldp");
        op(4'h2, 8'h01, 1'b1, 8'h00, "t3.ldh");
        op(4'h1, 8'h00, 1'b1, 8'h00, "t3.ldl");
        op(4'h6, 8'h01, 1'b1, 8'h00, "t3.sel");
        op(4'h4, 8'h00, 1'b0, 8'h01, "t3.run");
        for (int j = 1; j <= 256; j++) idle(j == 256, 8'h00, "t3.hi");
        op(4'h6, 8'h00, 1'b1, 8'h00, "t3.sel0");

        // STOP freezes, RUN restarts, LDL/LDP mid-run deferred
        op(4'h2, 8'h00, 1'b1, 8'h00, "t4.ldh");
        op(4'h1, 8'h0A, 1'b1, 8'h00, "t4.ldl");
        op(4'h4, 8'h00, 1'b0, 8'h0A, "t4.run");
        for (int i = 9; i >= 6; i--) idle(1'b0, 8'(i), "t4.cnt");
        op(4'h5, 8'h00, 1'b1, 8'h06, "t4.stop");
        idle(1'b1, 8'h06, "t4.frozen");
        idle(1'b1, 8'h06, "t4.frozen");
        op(4'h4, 8'h00, 1'b0, 8'h0A, "t4.rerun");
        idle(1'b0, 8'h09, "t4.cnt9");
        op(4'h4, 8'h00, 1'b0, 8'h0A, "t4.restart");
        op(4'h1, 8'h03, 1'b0, 8'h09, "t4.ldl_run");
        for (int i = 8; i >= 1; i--) idle(1'b0, 8'(i), "t4.tail");
        idle(1'b1, 8'h00, "t4.done");
        op(4'h4, 8'h00, 1'b0, 8'h03, "t4.newrel");
        op(4'h3, 8'h01, 1'b0, 8'h02, "t4.ldp_run");
        idle(1'b0, 8'h01, "t4.p0");
        idle(1'b1, 8'h00, "t4.done2");

        // Unused opcode is a no-op
        op(4'hF, 8'hFF, 1'b1, 8'h00, "t5.opf");

        // Zero-length wait
        op(4'h1, 8'h00, 1'b1, 8'h00, "t5.ldl");
        op(4'h2, 8'h00, 1'b1, 8'h00, "t5.ldh");
        op(4'h4, 8'h00, 1'b1, 8'h00, "t5.run0");
        idle(1'b1, 8'h00, "t5.idle");

        // Async reset mid-run (N=100, P=1)
        op(4'h1, 8'h64, 1'b1, 8'h00, "t6.ldl");
        op(4'h4, 8'h00, 1'b0, 8'h64, "t6.run");
        idle(1'b0, 8'h64, "t6.pre");
        idle(1'b0, 8'h63, "t6.dec");
        #2 reset = 1'b0;
        #1;
        check_bit("t6.rst.ready", ready, 1'b1);
        check_byte("t6.rst.count", count_o, 8'h00);
        @(posedge clock);
        #1 reset = 1'b1;
        idle(1'b1, 8'h00, "t6.noresume");
        idle(1'b1, 8'h00, "t6.noresume");
        op(4'h4, 8'h00, 1'b1, 8'h00, "t6.run_rst_reload");

`ifdef SEQ_TIMER_STICKY_EN
        check_bit("t7.rst.expired", expired, 1'b0);
        step(1'b1, 4'h1, 8'h02, 1'b1, 8'h00, 1'b1, 1'b0, "t7.ldl");
        step(1'b1, 4'h4, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0, "t7.run");
        step(1'b0, 4'h0, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, "t7.cnt");
        step(1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, "t7.exp");
        step(1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, "t7.sticky");
        step(1'b1, 4'h7, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "t7.clr");
        step(1'b1, 4'h4, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0, "t7.run2");
        step(1'b0, 4'h0, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, "t7.cnt2");
        step(1'b1, 4'h7, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, "t7.clr_vs_exp");
        step(1'b1, 4'h7, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "t7.clr2");
        step(1'b1, 4'h4, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0, "t7.run3");
        step(1'b1, 4'h5, 8'h00, 1'b1, 8'h02, 1'b1, 1'b0, "t7.stop");
        step(1'b0, 4'h0, 8'h00, 1'b1, 8'h02, 1'b1, 1'b0, "t7.stop_noexp");
`else
        op(4'h7, 8'h00, 1'b1, 8'h00, "t7.op7nop");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
